// File: rtl/mem_port_arbiter_pkg.sv
// Shared types, widths and parameter-range helpers for the SRAM port arbiter.
package mem_port_arbiter_pkg;

   localparam int unsigned ADDR_W   = 32;
   localparam int unsigned DATA_W   = 32;
   localparam int unsigned WEN_W    = 4;
   localparam int unsigned LAT_W    = 2;
   localparam int unsigned STARVE_W = 4;
   localparam int unsigned PERF_W   = 32;

   localparam int unsigned SRAM_LAT_MIN   = 1;
   localparam int unsigned SRAM_LAT_MAX   = 3;
   localparam int unsigned STARVE_MAX_MIN = 1;
   localparam int unsigned STARVE_MAX_LIM = 15;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } arb_state_e;

   typedef enum logic {
      OWN_INST = 1'b0,
      OWN_DATA = 1'b1
   } arb_owner_e;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [WEN_W-1:0]  wen;
      logic [DATA_W-1:0] wdata;
   } sram_cmd_t;

   function automatic logic params_legal(input int unsigned sram_lat, input int unsigned starve_max);
      return (sram_lat >= SRAM_LAT_MIN) && (sram_lat <= SRAM_LAT_MAX) &&
             (starve_max >= STARVE_MAX_MIN) && (starve_max <= STARVE_MAX_LIM);
   endfunction

endpackage

// File: rtl/mem_port_arbiter_perf_counters.sv
// Grant/conflict event counters for the SRAM port arbiter; present only when ARB_PERF_CNT_EN is defined.
`ifdef ARB_PERF_CNT_EN
module arb_perf_counters
   import mem_port_arbiter_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              inst_gnt_i,
   input  logic              data_gnt_i,
   input  logic              conflict_i,
   output logic [PERF_W-1:0] perf_inst_grants_o,
   output logic [PERF_W-1:0] perf_data_grants_o,
   output logic [PERF_W-1:0] perf_conflicts_o
);

   logic [PERF_W-1:0] inst_q, data_q, confl_q;

   // Free-running wrapping counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         inst_q  <= '0;
         data_q  <= '0;
         confl_q <= '0;
      end else begin
         if (inst_gnt_i) inst_q  <= inst_q + PERF_W'(1);
         if (data_gnt_i) data_q  <= data_q + PERF_W'(1);
         if (conflict_i) confl_q <= confl_q + PERF_W'(1);
      end
   end

   assign perf_inst_grants_o = inst_q;
   assign perf_data_grants_o = data_q;
   assign perf_conflicts_o   = confl_q;

endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port SRAM between instruction fetch and data access, one transaction in flight.
// Optional ARB_PERF_CNT_EN adds grant/conflict performance counter outputs.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned SRAM_LAT   = 1,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              inst_req,
   input  logic [ADDR_W-1:0] inst_addr,
   output logic              inst_addr_ok,
   output logic              inst_data_ok,
   output logic [DATA_W-1:0] inst_rdata,
   input  logic              data_req,
   input  logic [WEN_W-1:0]  data_wen,
   input  logic [ADDR_W-1:0] data_addr,
   input  logic [DATA_W-1:0] data_wdata,
   output logic              data_addr_ok,
   output logic              data_data_ok,
   output logic [DATA_W-1:0] data_rdata,
   output logic              sram_en,
   output logic [WEN_W-1:0]  sram_wen,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [DATA_W-1:0] sram_wdata,
   input  logic [DATA_W-1:0] sram_rdata,
   output logic              busy
`ifdef ARB_PERF_CNT_EN
   ,
   output logic [PERF_W-1:0] perf_inst_grants,
   output logic [PERF_W-1:0] perf_data_grants,
   output logic [PERF_W-1:0] perf_conflicts
`endif
);

   if (!params_legal(SRAM_LAT, STARVE_MAX)) begin : g_param_check
      $error("mem_port_arbiter: SRAM_LAT must be 1..3 and STARVE_MAX 1..15");
   end

   arb_state_e           state_q, state_d;
   arb_owner_e           owner_q, owner_d;
   logic                 drop_q, drop_d;
   logic                 wr_q, wr_d;
   logic [LAT_W-1:0]     lat_q, lat_d;
   logic [STARVE_W-1:0]  starve_q, starve_d;

   logic      grant_ok, resp, starve_hit, inst_gnt, data_gnt;
   sram_cmd_t cmd;

   // Grant window: idle, or the response cycle of the current transaction.
   always_comb begin
      resp       = !reset && (state_q == ST_WAIT) && (lat_q == LAT_W'(1));
      grant_ok   = !reset && ((state_q == ST_IDLE) || resp);
      starve_hit = (starve_q == STARVE_W'(STARVE_MAX));
      data_gnt   = grant_ok && data_req && !(inst_req && !flush && starve_hit);
      inst_gnt   = grant_ok && inst_req && !flush && !data_gnt;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         owner_q  <= OWN_INST;
         drop_q   <= 1'b0;
         wr_q     <= 1'b0;
         lat_q    <= '0;
         starve_q <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         drop_q   <= drop_d;
         wr_q     <= wr_d;
         lat_q    <= lat_d;
         starve_q <= starve_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      drop_d   = drop_q;
      wr_d     = wr_q;
      lat_d    = lat_q;
      starve_d = starve_q;

      // Saturates so a flushed-but-requesting fetch still wins once the flush lifts.
      if (inst_gnt)
         starve_d = '0;
      else if (data_gnt && inst_req && !starve_hit)
         starve_d = starve_q + STARVE_W'(1);

      if (inst_gnt || data_gnt) begin
         state_d = ST_WAIT;
         owner_d = data_gnt ? OWN_DATA : OWN_INST;
         drop_d  = 1'b0;
         wr_d    = data_gnt && (data_wen != '0);
         lat_d   = LAT_W'(SRAM_LAT);
      end else if (state_q == ST_WAIT) begin
         if (lat_q == LAT_W'(1)) begin
            state_d = ST_IDLE;
            drop_d  = 1'b0;
            wr_d    = 1'b0;
            lat_d   = '0;
         end else begin
            lat_d = lat_q - LAT_W'(1);
            if (flush && (owner_q == OWN_INST)) drop_d = 1'b1;
         end
      end
   end

   always_comb begin
      cmd = '0;
      if (data_gnt) begin
         cmd.addr  = data_addr;
         cmd.wen   = data_wen;
         cmd.wdata = data_wdata;
      end else if (inst_gnt) begin
         cmd.addr  = inst_addr;
      end

      inst_addr_ok = inst_gnt;
      data_addr_ok = data_gnt;
      sram_en      = inst_gnt || data_gnt;
      sram_addr    = cmd.addr;
      sram_wen     = cmd.wen;
      sram_wdata   = cmd.wdata;

      // A flush landing on the response cycle itself also cancels the fetch.
      inst_data_ok = resp && (owner_q == OWN_INST) && !drop_q && !flush;
      data_data_ok = resp && (owner_q == OWN_DATA);
      inst_rdata   = inst_data_ok ? sram_rdata : '0;
      data_rdata   = (data_data_ok && !wr_q) ? sram_rdata : '0;
      busy         = !reset && (state_q == ST_WAIT);
   end

`ifdef ARB_PERF_CNT_EN
   arb_perf_counters u_perf (
      .clk                (clk),
      .reset              (reset),
      .inst_gnt_i         (inst_gnt),
      .data_gnt_i         (data_gnt),
      .conflict_i         (grant_ok && inst_req && data_req),
      .perf_inst_grants_o (perf_inst_grants),
      .perf_data_grants_o (perf_data_grants),
      .perf_conflicts_o   (perf_conflicts)
   );
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: DUT a runs SRAM_LAT=1, DUT b runs SRAM_LAT=2; both see the same requester stimulus.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        reset, flush, inst_req, data_req;
   logic [31:0] inst_addr, data_addr, data_wdata;
   logic [3:0]  data_wen;

   logic        a_inst_addr_ok, a_inst_data_ok, a_data_addr_ok, a_data_data_ok, a_sram_en, a_busy;
   logic [31:0] a_inst_rdata, a_data_rdata, a_sram_addr, a_sram_wdata, a_sram_rdata;
   logic [3:0]  a_sram_wen;
   logic        b_inst_addr_ok, b_inst_data_ok, b_data_addr_ok, b_data_data_ok, b_sram_en, b_busy;
   logic [31:0] b_inst_rdata, b_data_rdata, b_sram_addr, b_sram_wdata, b_sram_rdata;
   logic [3:0]  b_sram_wen;
`ifdef ARB_PERF_CNT_EN
   logic [31:0] a_perf_inst, a_perf_data, a_perf_confl, b_perf_inst, b_perf_data, b_perf_confl;
`endif

   logic [31:0] mem_a [0:63];
   logic [31:0] mem_b [0:63];
   logic [31:0] rd_b_s1;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.SRAM_LAT(1), .STARVE_MAX(4)) dut_a (
      .clk(clk), .reset(reset), .flush(flush),
      .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(a_inst_addr_ok),
      .inst_data_ok(a_inst_data_ok), .inst_rdata(a_inst_rdata),
      .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr), .data_wdata(data_wdata),
      .data_addr_ok(a_data_addr_ok), .data_data_ok(a_data_data_ok), .data_rdata(a_data_rdata),
      .sram_en(a_sram_en), .sram_wen(a_sram_wen), .sram_addr(a_sram_addr),
      .sram_wdata(a_sram_wdata), .sram_rdata(a_sram_rdata), .busy(a_busy)
`ifdef ARB_PERF_CNT_EN
      , .perf_inst_grants(a_perf_inst), .perf_data_grants(a_perf_data), .perf_conflicts(a_perf_confl)
`endif
   );

   mem_port_arbiter #(.SRAM_LAT(2), .STARVE_MAX(4)) dut_b (
      .clk(clk), .reset(reset), .flush(flush),
      .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(b_inst_addr_ok),
      .inst_data_ok(b_inst_data_ok), .inst_rdata(b_inst_rdata),
      .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr), .data_wdata(data_wdata),
      .data_addr_ok(b_data_addr_ok), .data_data_ok(b_data_data_ok), .data_rdata(b_data_rdata),
      .sram_en(b_sram_en), .sram_wen(b_sram_wen), .sram_addr(b_sram_addr),
      .sram_wdata(b_sram_wdata), .sram_rdata(b_sram_rdata), .busy(b_busy)
`ifdef ARB_PERF_CNT_EN
      , .perf_inst_grants(b_perf_inst), .perf_data_grants(b_perf_data), .perf_conflicts(b_perf_confl)
`endif
   );

   // SRAM models: a has one cycle of read latency, b has two.
   always @(posedge clk) begin
      if (a_sram_en) begin
         for (int k = 0; k < 4; k++)
            if (a_sram_wen[k]) mem_a[a_sram_addr[7:2]][8*k +: 8] <= a_sram_wdata[8*k +: 8];
         a_sram_rdata <= mem_a[a_sram_addr[7:2]];
      end
      if (b_sram_en) begin
         for (int k = 0; k < 4; k++)
            if (b_sram_wen[k]) mem_b[b_sram_addr[7:2]][8*k +: 8] <= b_sram_wdata[8*k +: 8];
         rd_b_s1 <= mem_b[b_sram_addr[7:2]];
      end
      b_sram_rdata <= rd_b_s1;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      reset = 1'b1; flush = 1'b0; inst_req = 1'b0; data_req = 1'b0;
      inst_addr = '0; data_addr = '0; data_wdata = '0; data_wen = '0;
      tick(); tick();
      inst_req = 1'b1; data_req = 1'b1; inst_addr = 32'h10; data_addr = 32'h14;
      #2;
      checks++; if (a_inst_addr_ok !== 1'b0) begin failures++; $display("FAIL reset_inst_grant got=%b exp=0", a_inst_addr_ok); end
      checks++; if (a_data_addr_ok !== 1'b0) begin failures++; $display("FAIL reset_data_grant got=%b exp=0", a_data_addr_ok); end
      checks++; if (a_sram_en !== 1'b0) begin failures++; $display("FAIL reset_sram_en got=%b exp=0", a_sram_en); end
      checks++; if (b_data_addr_ok !== 1'b0) begin failures++; $display("FAIL reset_b_data_grant got=%b exp=0", b_data_addr_ok); end
      tick();
      reset = 1'b0; inst_req = 1'b0; data_req = 1'b0;
      #2;
      checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", a_busy); end
      checks++; if ({a_inst_data_ok, a_data_data_ok} !== 2'b00) begin failures++; $display("FAIL reset_data_ok got=%b exp=00", {a_inst_data_ok, a_data_data_ok}); end
      tick();
   endtask

   task automatic test_lone_inst;
      inst_req = 1'b1; inst_addr = 32'h0000_0010;
      #2;
      checks++; if (a_inst_addr_ok !== 1'b1) begin failures++; $display("FAIL lone_addr_ok got=%b exp=1", a_inst_addr_ok); end
      checks++; if (a_sram_addr !== 32'h10) begin failures++; $display("FAIL lone_sram_addr got=%h exp=00000010", a_sram_addr); end
      checks++; if (a_sram_wen !== 4'h0) begin failures++; $display("FAIL lone_sram_wen got=%h exp=0", a_sram_wen); end
      tick();
      inst_req = 1'b0;
      #2;
      checks++; if (a_inst_data_ok !== 1'b1) begin failures++; $display("FAIL lone_data_ok got=%b exp=1", a_inst_data_ok); end
      checks++; if (a_inst_rdata !== 32'h2401_0001) begin failures++; $display("FAIL lone_rdata got=%h exp=24010001", a_inst_rdata); end
      checks++; if (a_busy !== 1'b1) begin failures++; $display("FAIL lone_busy got=%b exp=1", a_busy); end
      tick();
      #2;
      checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL lone_idle_busy got=%b exp=0", a_busy); end
      checks++; if (a_inst_rdata !== 32'h0) begin failures++; $display("FAIL lone_rdata_idle got=%h exp=0", a_inst_rdata); end
      tick();
   endtask

   task automatic test_back_to_back;
      logic [31:0] exp_rd;
      for (int i = 0; i < 4; i++) begin
         inst_req = 1'b1; inst_addr = 32'(4 * i);
         #2;
         checks++; if (a_inst_addr_ok !== 1'b1) begin failures++; $display("FAIL b2b_grant[%0d] got=%b exp=1", i, a_inst_addr_ok); end
         checks++; if (a_sram_addr !== 32'(4 * i)) begin failures++; $display("FAIL b2b_addr[%0d] got=%h exp=%h", i, a_sram_addr, 32'(4 * i)); end
         if (i > 0) begin
            exp_rd = 32'hA000_0000 | 32'(i - 1);
            checks++; if (a_inst_data_ok !== 1'b1 || a_inst_rdata !== exp_rd) begin
               failures++; $display("FAIL b2b_resp[%0d] got=%b/%h exp=1/%h", i, a_inst_data_ok, a_inst_rdata, exp_rd); end
         end
         tick();
      end
      inst_req = 1'b0;
      #2;
      checks++; if (a_inst_data_ok !== 1'b1 || a_inst_rdata !== 32'hA000_0003) begin
         failures++; $display("FAIL b2b_last got=%b/%h exp=1/a0000003", a_inst_data_ok, a_inst_rdata); end
      tick(); tick();
   endtask

   task automatic test_reset_mid_op;
      inst_req = 1'b1; inst_addr = 32'h8;
      #2;
      checks++; if (b_inst_addr_ok !== 1'b1) begin failures++; $display("FAIL rmid_grant got=%b exp=1", b_inst_addr_ok); end
      tick();
      inst_req = 1'b0; reset = 1'b1;
      #2;
      checks++; if (a_inst_data_ok !== 1'b0) begin failures++; $display("FAIL rmid_a_data_ok got=%b exp=0", a_inst_data_ok); end
      tick();
      reset = 1'b0;
      #2;
      checks++; if (b_busy !== 1'b0) begin failures++; $display("FAIL rmid_busy got=%b exp=0", b_busy); end
      checks++; if (b_inst_data_ok !== 1'b0) begin failures++; $display("FAIL rmid_b_data_ok got=%b exp=0", b_inst_data_ok); end
      tick();
      #2;
      checks++; if ({a_inst_data_ok, b_inst_data_ok} !== 2'b00) begin failures++; $display("FAIL rmid_late_data_ok got=%b exp=00", {a_inst_data_ok, b_inst_data_ok}); end
      tick();
   endtask

   task automatic test_contention;
      int  j;
      logic exp_d, prev_d;
      j = 0;
      inst_req = 1'b1; inst_addr = 32'h20; data_req = 1'b1; data_wen = 4'hF;
      for (int k = 0; k < 10; k++) begin
         data_addr  = 32'h40 + 32'(4 * j);
         data_wdata = 32'hD000_0000 | 32'(j);
         #2;
         exp_d = ((k % 5) != 4);
         checks++; if ({a_data_addr_ok, a_inst_addr_ok} !== {exp_d, !exp_d}) begin
            failures++; $display("FAIL cont_grant[%0d] got(d,i)=%b%b exp=%b%b", k, a_data_addr_ok, a_inst_addr_ok, exp_d, !exp_d); end
         if (k > 0) begin
            prev_d = (((k - 1) % 5) != 4);
            if (prev_d) begin
               checks++; if (a_data_data_ok !== 1'b1 || a_data_rdata !== 32'h0) begin
                  failures++; $display("FAIL cont_wr_resp[%0d] got=%b/%h exp=1/00000000", k, a_data_data_ok, a_data_rdata); end
            end else begin
               checks++; if (a_inst_data_ok !== 1'b1 || a_inst_rdata !== 32'hA000_0008) begin
                  failures++; $display("FAIL cont_inst_resp[%0d] got=%b/%h exp=1/a0000008", k, a_inst_data_ok, a_inst_rdata); end
            end
         end
         if (exp_d) j++;
         tick();
      end
      inst_req = 1'b0; data_req = 1'b0; data_wen = 4'h0;
      #2;
      checks++; if (a_inst_data_ok !== 1'b1) begin failures++; $display("FAIL cont_tail got=%b exp=1", a_inst_data_ok); end
      tick();
      checks++; if (mem_a[16] !== 32'hD000_0000) begin failures++; $display("FAIL cont_mem16 got=%h exp=d0000000", mem_a[16]); end
      checks++; if (mem_a[23] !== 32'hD000_0007) begin failures++; $display("FAIL cont_mem23 got=%h exp=d0000007", mem_a[23]); end
`ifdef ARB_PERF_CNT_EN
      checks++; if (a_perf_data !== 32'd8) begin failures++; $display("FAIL perf_data got=%0d exp=8", a_perf_data); end
      checks++; if (a_perf_inst !== 32'd2) begin failures++; $display("FAIL perf_inst got=%0d exp=2", a_perf_inst); end
      checks++; if (a_perf_confl !== 32'd10) begin failures++; $display("FAIL perf_confl got=%0d exp=10", a_perf_confl); end
`endif
      tick();
   endtask

   task automatic test_flush;
      inst_req = 1'b1; inst_addr = 32'h10;
      #2;
      checks++; if (b_inst_addr_ok !== 1'b1) begin failures++; $display("FAIL flush_grant got=%b exp=1", b_inst_addr_ok); end
      tick();
      inst_req = 1'b0; flush = 1'b1;
      #2;
      checks++; if (b_busy !== 1'b1) begin failures++; $display("FAIL flush_busy got=%b exp=1", b_busy); end
      tick();
      flush = 1'b0;
      #2;
      checks++; if (b_inst_data_ok !== 1'b0) begin failures++; $display("FAIL flush_dropped got=%b exp=0", b_inst_data_ok); end
      checks++; if (b_inst_rdata !== 32'h0) begin failures++; $display("FAIL flush_rdata got=%h exp=0", b_inst_rdata); end
      tick();
      #2;
      checks++; if (b_busy !== 1'b0) begin failures++; $display("FAIL flush_idle got=%b exp=0", b_busy); end
      flush = 1'b1; inst_req = 1'b1; inst_addr = 32'h0;
      data_req = 1'b1; data_wen = 4'h0; data_addr = 32'h14;
      #1;
      checks++; if ({a_inst_addr_ok, a_data_addr_ok} !== 2'b01) begin
         failures++; $display("FAIL flush_data_grant got(i,d)=%b%b exp=01", a_inst_addr_ok, a_data_addr_ok); end
      checks++; if (b_data_addr_ok !== 1'b1) begin failures++; $display("FAIL flush_b_data_grant got=%b exp=1", b_data_addr_ok); end
      tick();
      data_req = 1'b0;
      #2;
      checks++; if (a_data_data_ok !== 1'b1 || a_data_rdata !== 32'hA000_0005) begin
         failures++; $display("FAIL flush_data_resp got=%b/%h exp=1/a0000005", a_data_data_ok, a_data_rdata); end
      checks++; if ({a_inst_addr_ok, a_sram_en} !== 2'b00) begin
         failures++; $display("FAIL flush_inst_blocked got=%b exp=00", {a_inst_addr_ok, a_sram_en}); end
      tick();
      flush = 1'b0; inst_req = 1'b0;
      tick();
   endtask

   initial begin
      for (int i = 0; i < 64; i++) begin
         mem_a[i] = 32'hA000_0000 | 32'(i);
         mem_b[i] = 32'hA000_0000 | 32'(i);
      end
      mem_a[4] = 32'h2401_0001;
      mem_b[4] = 32'h2401_0001;
      a_sram_rdata = '0; b_sram_rdata = '0; rd_b_s1 = '0;
      #1;
      test_reset();
      test_lone_inst();
      test_back_to_back();
      test_reset_mid_op();
      test_contention();
      test_flush();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
